// File: rtl/ibf_pkg.sv
// Shared definitions for the IBF ingress feeder: segment count helper,
// credit counter width helper, FSM state encoding and the bubble constant.
package ibf_pkg;

  // Number of input segments that make up one chain word.
  function automatic int calc_segs(input int data_width, input int seg_width);
    return data_width / seg_width;
  endfunction

  // Bits needed to hold a credit count in 0..credits inclusive.
  function automatic int credit_width(input int credits);
    return $clog2(credits + 1);
  endfunction

  // FILL accepts segments; HOLD parks a completed word until a credit exists.
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } feed_state_e;

  // Zero word driven into the free-running chain on every non-issue cycle.
  // Wide enough for any sane din_mod; callers slice off what they need.
  localparam int                      BUBBLE_MAX_W = 1024;
  localparam logic [BUBBLE_MAX_W-1:0] BUBBLE       = '0;

endpackage

// File: rtl/ibf_valid_delay.sv
// Fixed-latency sideband shift register that tracks words through the IBF
// chain. DEPTH stages; DEPTH=1 is a single flop.
module ibf_valid_delay #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  // Shift the sideband one stage per clock; reset flushes every stage.
  // NOTE: this array is cleared on reset on purpose -- it carries valid bits,
  // and a stale 1 left in any stage would surface as a spurious net_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ibf_ingress_feeder.sv
// Ingress feeder for the first inverse-butterfly stage. Packs SEG_WIDTH
// beats MS-first into DATA_WIDTH words, tags each with the packet mode,
// issues one registered word per credit into the free-running chain and
// regenerates valid/last aligned with the chain output.
// Optional build macro IBF_FEEDER_KEEP_EN adds the net_keep output.
module ibf_ingress_feeder
  import ibf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SEG_WIDTH  = 8,
  parameter int MODE_WIDTH = 2,
  parameter int PIPE_DEPTH = 5,
  parameter int CREDITS    = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SEG_WIDTH-1:0]             s_data,
  input  logic [MODE_WIDTH-1:0]            s_mode,
  input  logic                             s_last,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [DATA_WIDTH+MODE_WIDTH-1:0] din_mod,
  output logic                             net_valid,
  output logic                             net_last,
  input  logic                             credit_ret
`ifdef IBF_FEEDER_KEEP_EN
  ,
  output logic [calc_segs(DATA_WIDTH, SEG_WIDTH)-1:0] net_keep
`endif
);

  localparam int SEGS  = calc_segs(DATA_WIDTH, SEG_WIDTH);
  localparam int SCW   = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam int CW    = credit_width(CREDITS);
  localparam int DIN_W = DATA_WIDTH + MODE_WIDTH;
`ifdef IBF_FEEDER_KEEP_EN
  localparam int DLY_W = 2 + SEGS;
`else
  localparam int DLY_W = 2;
`endif

  feed_state_e           state_q;
  logic                  s_ready_q;
  logic [SCW-1:0]        seg_cnt_q;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [MODE_WIDTH-1:0] mode_q, mode_d;
  logic                  first_beat_q;  // next accepted beat opens a packet
  logic                  last_q;        // held word closes its packet
  logic [CW-1:0]         credit_q;
  logic [DIN_W-1:0]      din_mod_q;
  logic [DLY_W-1:0]      dly_in, dly_out;
  logic                  beat, word_done, issue;

  // s_ready_q only ever rises in FILL, so it doubles as the FILL qualifier.
  assign beat      = s_valid && s_ready_q;
  assign word_done = beat && (s_last || (seg_cnt_q == SCW'(SEGS - 1)));
  assign issue     = (state_q == HOLD) && (credit_q != '0);

  // Merge the incoming beat into the accumulator; a fresh word starts from
  // zero so a short last word leaves its unfilled low segments cleared.
  // NOTE: every always_comb output gets a default before any conditional
  // write, otherwise the tool infers a latch for the uncovered paths.
  always_comb begin
    word_d = (seg_cnt_q == '0) ? '0 : word_q;
    for (int k = 0; k < SEGS; k++) begin
      if (seg_cnt_q == SCW'(k)) word_d[DATA_WIDTH-1-k*SEG_WIDTH -: SEG_WIDTH] = s_data;
    end
    mode_d = first_beat_q ? s_mode : mode_q;
  end

  // FILL/HOLD sequencer with registered s_ready and the registered din_mod.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      s_ready_q    <= 1'b1;
      seg_cnt_q    <= '0;
      word_q       <= '0;
      mode_q       <= '0;
      first_beat_q <= 1'b1;
      last_q       <= 1'b0;
      din_mod_q    <= '0;
    end else begin
      din_mod_q <= issue ? {word_q, mode_q} : BUBBLE[DIN_W-1:0];
      case (state_q)
        FILL: begin
          if (beat) begin
            word_q       <= word_d;
            mode_q       <= mode_d;
            first_beat_q <= s_last;
            if (word_done) begin
              seg_cnt_q <= '0;
              last_q    <= s_last;
              state_q   <= HOLD;
              s_ready_q <= 1'b0;
            end else begin
              seg_cnt_q <= seg_cnt_q + SCW'(1);
            end
          end
        end
        HOLD: begin
          if (issue) begin
            state_q   <= FILL;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= FILL;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Credit counter: issue spends, credit_ret refunds, saturating at CREDITS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= CW'(CREDITS);
    end else if (issue && !credit_ret) begin
      credit_q <= credit_q - CW'(1);
    end else if (credit_ret && !issue && (credit_q != CW'(CREDITS))) begin
      credit_q <= credit_q + CW'(1);
    end
  end

`ifdef IBF_FEEDER_KEEP_EN
  logic [SEGS-1:0] keep_q, keep_d;

  // Mark each filled segment; bit SEGS-1 is the MS (first) segment.
  always_comb begin
    keep_d = (seg_cnt_q == '0) ? '0 : keep_q;
    for (int k = 0; k < SEGS; k++) begin
      if (seg_cnt_q == SCW'(k)) keep_d[SEGS-1-k] = 1'b1;
    end
  end

  // Keep mask follows the accumulator beat for beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keep_q <= '0;
    end else if (beat && (state_q == FILL)) begin
      keep_q <= keep_d;
    end
  end

  assign dly_in   = {issue, issue && last_q, {SEGS{issue}} & keep_q};
  assign net_keep = dly_out[SEGS-1:0];
`else
  assign dly_in = {issue, issue && last_q};
`endif

  // One extra stage beyond the chain depth accounts for the din_mod register.
  ibf_valid_delay #(
    .WIDTH (DLY_W),
    .DEPTH (PIPE_DEPTH + 1)
  ) u_valid_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (dly_in),
    .dout_o (dly_out)
  );

  // Outputs are held low while reset is asserted; s_ready comes up the
  // moment reset releases because the FSM wakes in FILL.
  assign s_ready   = s_ready_q && rst_n;
  assign din_mod   = din_mod_q;
  assign net_valid = dly_out[DLY_W-1];
  assign net_last  = dly_out[DLY_W-2];

endmodule

// File: tb/tb_ibf_ingress_feeder.sv
// Directed bench for ibf_ingress_feeder (CREDITS=2, PIPE_DEPTH=5).
// Build with IBF_FEEDER_KEEP_EN to also check net_keep.
module tb_ibf_ingress_feeder;

  localparam int DW   = 32;
  localparam int SW   = 8;
  localparam int MW   = 2;
  localparam int PD   = 5;
  localparam int CR   = 2;
  localparam int SEGS = DW / SW;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic [SW-1:0] s_data     = '0;
  logic [MW-1:0] s_mode     = '0;
  logic          s_last     = 1'b0;
  logic          s_valid    = 1'b0;
  logic          credit_ret = 1'b0;
  logic          s_ready;
  logic [DW+MW-1:0] din_mod;
  logic          net_valid;
  logic          net_last;
`ifdef IBF_FEEDER_KEEP_EN
  logic [SEGS-1:0] net_keep;
`endif

  always #5 clk = ~clk;

  ibf_ingress_feeder #(
    .DATA_WIDTH (DW),
    .SEG_WIDTH  (SW),
    .MODE_WIDTH (MW),
    .PIPE_DEPTH (PD),
    .CREDITS    (CR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_mode     (s_mode),
    .s_last     (s_last),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .din_mod    (din_mod),
    .net_valid  (net_valid),
    .net_last   (net_last),
    .credit_ret (credit_ret)
`ifdef IBF_FEEDER_KEEP_EN
    ,
    .net_keep   (net_keep)
`endif
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int cr_cyc;

  // Logs of every non-bubble din_mod and every net_valid, stamped by edge.
  logic [DW+MW-1:0] dq[$];
  int               dq_cyc[$];
  int               nv_cyc[$];
  logic             nv_last[$];
  logic [SEGS-1:0]  nv_keep[$];

  always @(posedge clk) begin
    if (din_mod !== '0) begin
      dq.push_back(din_mod);
      dq_cyc.push_back(cyc);
    end
    if (net_valid === 1'b1) begin
      nv_cyc.push_back(cyc);
      nv_last.push_back(net_last);
`ifdef IBF_FEEDER_KEEP_EN
      nv_keep.push_back(net_keep);
`else
      nv_keep.push_back('0);
`endif
    end
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    dq.delete();
    dq_cyc.delete();
    nv_cyc.delete();
    nv_last.delete();
    nv_keep.delete();
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send_beat(input logic [SW-1:0] d, input logic [MW-1:0] m, input logic l);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_mode  = m;
    s_last  = l;
    while (s_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept_wait", 64'(n < 40), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_credit(input int n);
    repeat (n) begin
      credit_ret = 1'b1;
      @(negedge clk);
      credit_ret = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- Reset state ----
    idle(3);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_din_mod", 64'(din_mod), 64'd0);
    check("rst_net_valid", 64'(net_valid), 64'd0);
    check("rst_net_last", 64'(net_last), 64'd0);
    rst_n = 1'b1;
    #1;
    check("rel_s_ready", 64'(s_ready), 64'd1);
    check("rel_credit", 64'(dut.credit_q), 64'd2);
    @(negedge clk);
    clear_logs();

    // ---- Full packet, two words ----
    for (int i = 1; i <= 8; i++) send_beat(8'(i * 17), 2'b10, i == 8);
    idle(12);
    check("t1_nwords", 64'(dq.size()), 64'd2);
    check("t1_word0", 64'(dq[0]), {30'd0, 32'h11223344, 2'b10});
    check("t1_word1", 64'(dq[1]), {30'd0, 32'h55667788, 2'b10});
    check("t1_rate", 64'(dq_cyc[1] - dq_cyc[0]), 64'd5);
    check("t1_nvalid", 64'(nv_cyc.size()), 64'd2);
    check("t1_lat0", 64'(nv_cyc[0] - dq_cyc[0]), 64'd5);
    check("t1_lat1", 64'(nv_cyc[1] - dq_cyc[1]), 64'd5);
    check("t1_last0", 64'(nv_last[0]), 64'd0);
    check("t1_last1", 64'(nv_last[1]), 64'd1);
`ifdef IBF_FEEDER_KEEP_EN
    check("t1_keep0", 64'(nv_keep[0]), 64'hF);
    check("t1_keep1", 64'(nv_keep[1]), 64'hF);
`endif
    check("t1_credit0", 64'(dut.credit_q), 64'd0);
    pulse_credit(2);
    check("t1_credit_back", 64'(dut.credit_q), 64'd2);
    pulse_credit(1);
    check("credit_saturate", 64'(dut.credit_q), 64'd2);
    clear_logs();

    // ---- Short packet ----
    send_beat(8'hAA, 2'b01, 1'b0);
    send_beat(8'hBB, 2'b01, 1'b0);
    send_beat(8'hCC, 2'b01, 1'b1);
    idle(10);
    check("t2_nwords", 64'(dq.size()), 64'd1);
    check("t2_word", 64'(dq[0]), {30'd0, 32'hAABBCC00, 2'b01});
    check("t2_nvalid", 64'(nv_cyc.size()), 64'd1);
    check("t2_last", 64'(nv_last[0]), 64'd1);
    check("t2_lat", 64'(nv_cyc[0] - dq_cyc[0]), 64'd5);
`ifdef IBF_FEEDER_KEEP_EN
    check("t2_keep", 64'(nv_keep[0]), 64'b1110);
`endif
    check("t2_credit", 64'(dut.credit_q), 64'd1);
    pulse_credit(1);
    clear_logs();

    // ---- Credit exhaustion: three words, two credits ----
    for (int i = 1; i <= 12; i++) send_beat(8'(i), 2'b11, i == 12);
    idle(10);
    check("t3_stall_ready", 64'(s_ready), 64'd0);
    check("t3_stall_words", 64'(dq.size()), 64'd2);
    check("t3_stall_credit", 64'(dut.credit_q), 64'd0);
    cr_cyc = cyc;
    pulse_credit(1);
    idle(10);
    check("t3_nwords", 64'(dq.size()), 64'd3);
    check("t3_word2", 64'(dq[2]), {30'd0, 32'h090A0B0C, 2'b11});
    check("t3_issue_time", 64'(dq_cyc[2]), 64'(cr_cyc + 2));
    check("t3_credit_end", 64'(dut.credit_q), 64'd0);
    check("t3_ready_end", 64'(s_ready), 64'd1);
    check("t3_nvalid", 64'(nv_cyc.size()), 64'd3);
    check("t3_nv_time", 64'(nv_cyc[2]), 64'(cr_cyc + 7));
    check("t3_lasts", 64'({nv_last[0], nv_last[1], nv_last[2]}), 64'b001);

    // ---- Simultaneous issue and credit_ret at credit=1 ----
    pulse_credit(1);
    send_beat(8'hDE, 2'b01, 1'b0);
    send_beat(8'hAD, 2'b01, 1'b0);
    send_beat(8'hBE, 2'b01, 1'b0);
    send_beat(8'hEF, 2'b01, 1'b1);
    credit_ret = 1'b1;
    @(negedge clk);
    credit_ret = 1'b0;
    check("t4_credit", 64'(dut.credit_q), 64'd1);
    check("t4_din_mod", 64'(din_mod), {30'd0, 32'hDEADBEEF, 2'b01});
    check("t4_ready", 64'(s_ready), 64'd1);
    idle(10);
    pulse_credit(1);
    clear_logs();

    // ---- Reset mid-word with a word in flight ----
    send_beat(8'hA1, 2'b10, 1'b0);
    send_beat(8'hA2, 2'b10, 1'b0);
    send_beat(8'hA3, 2'b10, 1'b0);
    send_beat(8'hA4, 2'b10, 1'b1);
    send_beat(8'h77, 2'b11, 1'b0);
    send_beat(8'h66, 2'b11, 1'b0);
    check("t5_pre_issued", 64'(dq.size()), 64'd1);
    check("t5_pre_nvalid", 64'(nv_cyc.size()), 64'd0);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", 64'(s_ready), 64'd0);
    check("t5_rst_din_mod", 64'(din_mod), 64'd0);
    @(negedge clk);
    idle(2);
    clear_logs();
    rst_n = 1'b1;
    #1;
    check("t5_rel_ready", 64'(s_ready), 64'd1);
    check("t5_rel_credit", 64'(dut.credit_q), 64'd2);
    @(negedge clk);
    idle(15);
    check("t5_no_words", 64'(dq.size()), 64'd0);
    check("t5_no_nvalid", 64'(nv_cyc.size()), 64'd0);
    send_beat(8'h10, 2'b01, 1'b0);
    send_beat(8'h20, 2'b01, 1'b0);
    send_beat(8'h30, 2'b01, 1'b0);
    send_beat(8'h40, 2'b01, 1'b1);
    idle(10);
    check("t5_nwords", 64'(dq.size()), 64'd1);
    check("t5_word", 64'(dq[0]), {30'd0, 32'h10203040, 2'b01});
    check("t5_nvalid", 64'(nv_cyc.size()), 64'd1);
    pulse_credit(1);
    clear_logs();

    // ---- Mode change mid-packet, with an idle gap inside a word ----
    send_beat(8'hC1, 2'b10, 1'b0);
    send_beat(8'hC2, 2'b10, 1'b0);
    s_data = 8'hFF;
    idle(3);
    send_beat(8'hC3, 2'b10, 1'b0);
    send_beat(8'hC4, 2'b10, 1'b0);
    send_beat(8'hC5, 2'b01, 1'b0);
    send_beat(8'hC6, 2'b01, 1'b0);
    send_beat(8'hC7, 2'b01, 1'b0);
    send_beat(8'hC8, 2'b01, 1'b1);
    idle(12);
    check("t6_nwords", 64'(dq.size()), 64'd2);
    check("t6_word0", 64'(dq[0]), {30'd0, 32'hC1C2C3C4, 2'b10});
    check("t6_word1", 64'(dq[1]), {30'd0, 32'hC5C6C7C8, 2'b10});
    check("t6_last1", 64'(nv_last[1]), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
